// File: rtl/decoder_bscan_if.sv
// Pin and scan-strobe bundle for decoder_bscan.
// Optional bypass_sel signal exists only when BSCAN_BYPASS_EN is defined.
interface decoder_bscan_if #(
    parameter int unsigned DEC_W = 2
);
    localparam int unsigned OUT_W = 32'(1) << DEC_W;

    logic [DEC_W-1:0] code;
    logic             en;
    logic [OUT_W-1:0] y;
    logic             mode_in;
    logic             mode_out;
    logic             capture_dr;
    logic             shift_dr;
    logic             update_dr;
    logic             tdi;
    logic             tdo;
`ifdef BSCAN_BYPASS_EN
    logic             bypass_sel;
`endif

    // Driver side: board pins and TAP strobes
    modport master (
        output code, en, mode_in, mode_out, capture_dr, shift_dr, update_dr, tdi,
`ifdef BSCAN_BYPASS_EN
        output bypass_sel,
`endif
        input  y, tdo
    );

    // Decoder side
    modport slave (
        input  code, en, mode_in, mode_out, capture_dr, shift_dr, update_dr, tdi,
`ifdef BSCAN_BYPASS_EN
        input  bypass_sel,
`endif
        output y, tdo
    );
endinterface

// File: rtl/decoder_bscan.sv
// Registered binary-to-one-hot decoder wrapped in a boundary-scan register.
// Chain: sr[DEC_W-1:0] code cells, sr[DEC_W] en cell, sr[N-1:DEC_W+1] y cells;
// sr[0] is nearest tdi, tdo = sr[N-1].
// Optional feature: define BSCAN_BYPASS_EN to add bypass_sel and a 1-bit bypass register.
module decoder_bscan #(
    parameter int unsigned DEC_W = 2
) (
    input logic           clk,
    input logic           rst_n,
    decoder_bscan_if.slave bus
);
    localparam int unsigned OUT_W = 32'(1) << DEC_W;
    localparam int unsigned N     = DEC_W + 1 + OUT_W;

    logic             c_en;
    logic [DEC_W-1:0] c_code;
    logic [OUT_W-1:0] y_core;
    logic [OUT_W-1:0] y_q;
    logic [N-1:0]     sr;
    logic [N-1:0]     upd;
    logic             scan_sel_c;

`ifdef BSCAN_BYPASS_EN
    logic bp;

    // Boundary register is frozen while the bypass path is selected
    assign scan_sel_c = !bus.bypass_sel;

    // Single-bit bypass register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp <= 1'b0;
        end else if (bus.bypass_sel) begin
            if (bus.capture_dr) begin
                bp <= 1'b0;
            end else if (bus.shift_dr) begin
                bp <= bus.tdi;
            end
        end
    end

    assign bus.tdo = bus.bypass_sel ? bp : sr[N-1];
`else
    assign scan_sel_c = 1'b1;
    assign bus.tdo    = sr[N-1];
`endif

    // Core input select (INTEST) and one-hot decode
    always_comb begin
        c_en   = bus.en;
        c_code = bus.code;
        if (bus.mode_in) begin
            c_en   = upd[DEC_W];
            c_code = upd[DEC_W-1:0];
        end
        y_core = '0;
        if (c_en) begin
            y_core[c_code] = 1'b1;
        end
    end

    // Registered decoder output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= '0;
        end else begin
            y_q <= y_core;
        end
    end

    // Boundary shift register: capture has priority over shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (scan_sel_c) begin
            if (bus.capture_dr) begin
                sr <= {y_core, bus.en, bus.code};
            end else if (bus.shift_dr) begin
                sr <= {sr[N-2:0], bus.tdi};
            end
        end
    end

    // Update latches take the pre-edge shift register contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd <= '0;
        end else if (scan_sel_c && bus.update_dr) begin
            upd <= sr;
        end
    end

    // EXTEST drives the pins straight from the update latches
    assign bus.y = bus.mode_out ? upd[N-1:DEC_W+1] : y_q;

endmodule

// File: tb/tb_decoder_bscan.sv
// Directed self-checking bench for decoder_bscan (DEC_W=2, chain length 7).
// Bypass checks are included when BSCAN_BYPASS_EN is defined.
module tb_decoder_bscan;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    logic [6:0] dout;

    decoder_bscan_if #(.DEC_W(2)) bus ();

    decoder_bscan #(.DEC_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shift a 7-bit word in MSB first; returns the bits seen on tdo (old sr)
    task automatic shift_word(input logic [6:0] din, output logic [6:0] dq);
        for (int i = 6; i >= 0; i--) begin
            bus.tdi      = din[i];
            bus.shift_dr = 1'b1;
            dq[i]        = bus.tdo;
            tick();
        end
        bus.shift_dr = 1'b0;
        bus.tdi      = 1'b0;
    endtask

    task automatic pulse_capture();
        bus.capture_dr = 1'b1;
        tick();
        bus.capture_dr = 1'b0;
    endtask

    task automatic pulse_update();
        bus.update_dr = 1'b1;
        tick();
        bus.update_dr = 1'b0;
    endtask

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        rst_n          = 1'b0;
        bus.code       = 2'b00;
        bus.en         = 1'b0;
        bus.mode_in    = 1'b0;
        bus.mode_out   = 1'b0;
        bus.capture_dr = 1'b0;
        bus.shift_dr   = 1'b0;
        bus.update_dr  = 1'b0;
        bus.tdi        = 1'b0;
`ifdef BSCAN_BYPASS_EN
        bus.bypass_sel = 1'b0;
`endif
        #1;
        check("reset_y", 32'(bus.y), 32'h0);
        check("reset_tdo", 32'(bus.tdo), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: functional decode with one-cycle latency
        bus.en   = 1'b1;
        bus.code = 2'b10;
        #1;
        check("dec_latency", 32'(bus.y), 32'h0);
        tick();
        check("dec_10", 32'(bus.y), 32'h4);
        bus.en = 1'b0;
        tick();
        check("dec_en0", 32'(bus.y), 32'h0);

        // 2: capture (with simultaneous shift, capture wins), then shift out
        bus.code       = 2'b11;
        bus.en         = 1'b1;
        bus.capture_dr = 1'b1;
        bus.shift_dr   = 1'b1;
        bus.tdi        = 1'b0;
        tick();
        bus.capture_dr = 1'b0;
        bus.shift_dr   = 1'b0;
        check("cap_tdo_msb", 32'(bus.tdo), 32'h1);
        shift_word(7'b0000000, dout);
        check("cap_shift_out", 32'(dout), 32'h47);
        check("cap_tdo_after", 32'(bus.tdo), 32'h0);

        // 3: EXTEST from update latches
        bus.code     = 2'b00;
        bus.en       = 1'b1;
        shift_word(7'b0101000, dout);
        bus.mode_out = 1'b1;
        #1;
        check("ext_pre_update", 32'(bus.y), 32'h0);
        pulse_update();
        check("ext_y", 32'(bus.y), 32'h5);
        bus.code = 2'b11;
        tick();
        check("ext_pin_indep", 32'(bus.y), 32'h5);
        bus.mode_out = 1'b0;
        #1;
        check("ext_off_yq", 32'(bus.y), 32'h8);

        // 4: INTEST drives the core from update latches
        shift_word(7'b0000101, dout);
        pulse_update();
        bus.mode_in = 1'b1;
        bus.code    = 2'b11;
        bus.en      = 1'b0;
        tick();
        check("int_y", 32'(bus.y), 32'h2);
        pulse_capture();
        shift_word(7'b0000000, dout);
        check("int_capture", 32'(dout), 32'h13);
        bus.mode_in = 1'b0;

        // 5: reset in the middle of a shift
        shift_word(7'b1111000, dout);
        pulse_update();
        bus.code = 2'b00;
        bus.en   = 1'b1;
        bus.tdi      = 1'b1;
        bus.shift_dr = 1'b1;
        tick();
        tick();
        tick();
        bus.shift_dr = 1'b0;
        check("rst_pre_tdo", 32'(bus.tdo), 32'h1);
        bus.mode_out = 1'b1;
        #1;
        check("rst_pre_upd", 32'(bus.y), 32'hF);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_tdo", 32'(bus.tdo), 32'h0);
        check("rst_upd", 32'(bus.y), 32'h0);
        bus.mode_out = 1'b0;
        #1;
        check("rst_yq", 32'(bus.y), 32'h0);
        tick();
        rst_n    = 1'b1;
        bus.code = 2'b01;
        bus.en   = 1'b1;
        tick();
        pulse_capture();
        shift_word(7'b0000000, dout);
        check("rst_recapture", 32'(dout), 32'h15);

`ifdef BSCAN_BYPASS_EN
        // 6: bypass register path; boundary register must hold
        bus.code = 2'b10;
        bus.en   = 1'b1;
        pulse_capture();
        bus.bypass_sel = 1'b1;
        pulse_capture();
        check("bp_cap", 32'(bus.tdo), 32'h0);
        bus.shift_dr = 1'b1;
        bus.tdi = 1'b1;
        check("bp_tdo0", 32'(bus.tdo), 32'h0);
        tick();
        bus.tdi = 1'b0;
        check("bp_tdo1", 32'(bus.tdo), 32'h1);
        tick();
        bus.tdi = 1'b1;
        check("bp_tdo2", 32'(bus.tdo), 32'h0);
        tick();
        bus.shift_dr = 1'b0;
        pulse_update();
        bus.mode_out = 1'b1;
        #1;
        check("bp_upd_hold", 32'(bus.y), 32'h0);
        bus.mode_out   = 1'b0;
        bus.bypass_sel = 1'b0;
        #1;
        shift_word(7'b0000000, dout);
        check("bp_sr_hold", 32'(dout), 32'h26);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
